// File: rtl/joy_arbiter.sv
// ============================================================================
// joy_arbiter: two-player joystick synchroniser, debouncer and first-press
// arbiter with a registered valid/ready answer port.  Rev 1.0
// ============================================================================
`default_nettype none

module joy_arbiter #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] joy_l,
  input  logic [3:0] joy_r,
  input  logic       enable,
  input  logic       ans_ready,
  output logic       ans_valid,
  output logic       ans_player,
  output logic [1:0] ans_choice,
  output logic       armed
);

  localparam int              c_CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_PRE  = c_CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_REPORT  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  // index 0 = left player, index 1 = right player
  logic [1:0][3:0]      r_s1;
  logic [1:0][3:0]      r_s2;
  logic [1:0][3:0]      r_filt;
  logic [1:0][c_CW-1:0] r_cnt;

  state_t     r_state;
  logic       r_tok;
  logic       r_valid;
  logic       r_player;
  logic [1:0] r_choice;
  logic       r_armed;

  logic [1:0] w_legal;
  logic [1:0] w_rel;
  logic [1:0] w_settled;
  logic       w_tie;
  logic       w_win;
  logic [1:0] w_choice;

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Counter restarts when the next sync2 value differs, so the filtered
  // vector loads on the edge where the count reaches DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_filt <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= {joy_r, joy_l};
      r_s2 <= r_s1;
      for (int p = 0; p < 2; p++) begin
        if (r_s1[p] != r_s2[p]) begin
          r_cnt[p] <= '0;
        end else if (r_cnt[p] != c_LAST) begin
          r_cnt[p] <= r_cnt[p] + 1'b1;
          if (r_cnt[p] == c_PRE) r_filt[p] <= r_s2[p];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_legal[p]   = $onehot(r_filt[p]);
      w_rel[p]     = (r_filt[p] == 4'b0000);
      w_settled[p] = (r_cnt[p] == c_LAST);
    end
    w_tie    = w_legal[0] && w_legal[1];
    w_win    = w_tie ? r_tok : w_legal[1];
    w_choice = w_win ? enc(r_filt[1]) : enc(r_filt[0]);
  end

  // Arming also waits for both debouncers to settle, so a stick held through
  // reset is seen as pressed (not released) before the round can open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_tok    <= 1'b0;
      r_valid  <= 1'b0;
      r_player <= 1'b0;
      r_choice <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && (&w_rel) && (&w_settled)) begin
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end
        end
        S_ARMED: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
          end else if (|w_legal) begin
            r_state  <= S_REPORT;
            r_armed  <= 1'b0;
            r_valid  <= 1'b1;
            r_player <= w_win;
            r_choice <= w_choice;
            if (w_tie) r_tok <= ~r_tok;
          end
        end
        S_REPORT: begin
          if (ans_ready) begin
            r_state <= S_LOCKOUT;
            r_valid <= 1'b0;
          end
        end
        S_LOCKOUT: begin
          if (&w_rel) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ans_valid  = r_valid;
  assign ans_player = r_player;
  assign ans_choice = r_choice;
  assign armed      = r_armed;

endmodule

`default_nettype wire

// File: tb/tb_joy_arbiter.sv
// ============================================================================
// tb_joy_arbiter: directed self-checking bench for joy_arbiter, DEBOUNCE=4.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_joy_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] joy_l;
  logic [3:0] joy_r;
  logic       enable;
  logic       ans_ready;
  logic       ans_valid;
  logic       ans_player;
  logic [1:0] ans_choice;
  logic       armed;

  int n_cmp;
  int n_bad;

  joy_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .joy_l      (joy_l),
    .joy_r      (joy_r),
    .enable     (enable),
    .ans_ready  (ans_ready),
    .ans_valid  (ans_valid),
    .ans_player (ans_player),
    .ans_choice (ans_choice),
    .armed      (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance n rising edges, then sit on the following falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_armed(input string tag);
    int k;
    k = 0;
    while (!armed && k < 60) begin
      tick(1);
      k++;
    end
    check(tag, int'(armed), 1);
  endtask

  task automatic watch_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (ans_valid) seen++;
    end
  endtask

  task automatic accept(input string tag);
    ans_ready = 1'b1;
    tick(1);
    ans_ready = 1'b0;
    check(tag, int'(ans_valid), 0);
  endtask

  initial begin
    int seen;
    int drift;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; joy_l = 4'b0; joy_r = 4'b0; enable = 1'b0; ans_ready = 1'b0;
    tick(2);
    check("rst_valid",  int'(ans_valid),  0);
    check("rst_player", int'(ans_player), 0);
    check("rst_choice", int'(ans_choice), 0);
    check("rst_armed",  int'(armed),      0);

    // left single press
    rst_n = 1'b1;
    enable = 1'b1;
    wait_armed("t1_arm");
    joy_l = 4'b0100;
    tick(5);
    check("t1_valid_e5", int'(ans_valid), 0);
    tick(1);
    check("t1_valid_e6", int'(ans_valid),  1);
    check("t1_player",   int'(ans_player), 0);
    check("t1_choice",   int'(ans_choice), 2);
    check("t1_armed",    int'(armed),      0);
    tick(3);
    check("t1_hold", int'(ans_valid), 1);
    accept("t1_accept");
    joy_l = 4'b0;

    // tie: token starts left, then passes right
    wait_armed("t2_arm1");
    joy_l = 4'b0001; joy_r = 4'b1000;
    tick(6);
    check("t2_valid1",  int'(ans_valid),  1);
    check("t2_player1", int'(ans_player), 0);
    check("t2_choice1", int'(ans_choice), 0);
    accept("t2_accept1");
    joy_l = 4'b0; joy_r = 4'b0;
    wait_armed("t2_arm2");
    joy_l = 4'b0001; joy_r = 4'b1000;
    tick(6);
    check("t2_valid2",  int'(ans_valid),  1);
    check("t2_player2", int'(ans_player), 1);
    check("t2_choice2", int'(ans_choice), 3);
    accept("t2_accept2");
    joy_l = 4'b0; joy_r = 4'b0;

    // glitch, then illegal multi-bit, then legal
    wait_armed("t3_arm");
    joy_r = 4'b0100;
    tick(3);
    joy_r = 4'b0;
    watch_valid(12, seen);
    check("t3_glitch", seen, 0);
    check("t3_still_armed", int'(armed), 1);
    joy_l = 4'b0011;
    watch_valid(20, seen);
    check("t3_multibit", seen, 0);
    joy_l = 4'b0010;
    tick(5);
    check("t3_valid_e5", int'(ans_valid), 0);
    tick(1);
    check("t3_valid",  int'(ans_valid),  1);
    check("t3_player", int'(ans_player), 0);
    check("t3_choice", int'(ans_choice), 1);
    accept("t3_accept");
    joy_l = 4'b0;

    // lockout until both sticks released
    wait_armed("t4_arm");
    joy_r = 4'b0010;
    tick(6);
    check("t4_valid",  int'(ans_valid),  1);
    check("t4_player", int'(ans_player), 1);
    check("t4_choice", int'(ans_choice), 1);
    accept("t4_accept");
    joy_l = 4'b1000;
    watch_valid(20, seen);
    check("t4_locked", seen, 0);
    check("t4_not_armed", int'(armed), 0);
    joy_l = 4'b0;
    watch_valid(10, seen);
    check("t4_one_held", seen + int'(armed), 0);
    joy_r = 4'b0;
    wait_armed("t4_rearm");
    check("t4_no_valid", int'(ans_valid), 0);

    // ready while idle-valid is ignored; backpressure with enable dropping
    ans_ready = 1'b1;
    tick(3);
    ans_ready = 1'b0;
    check("t5_ready_noeffect", int'(armed), 1);
    joy_l = 4'b0100;
    tick(6);
    check("t5_valid", int'(ans_valid), 1);
    enable = 1'b0;
    drift = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ans_valid !== 1'b1 || ans_player !== 1'b0 || ans_choice !== 2'd2) drift++;
    end
    check("t5_stable", drift, 0);
    accept("t5_accept");
    joy_l = 4'b0;
    tick(12);
    check("t5_disabled", int'(armed), 0);
    enable = 1'b1;

    // reset during REPORT with a stick held across reset
    wait_armed("t6_arm");
    joy_r = 4'b0001;
    tick(6);
    check("t6_valid",  int'(ans_valid),  1);
    check("t6_player", int'(ans_player), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",  int'(ans_valid),  0);
    check("t6_rst_player", int'(ans_player), 0);
    check("t6_rst_choice", int'(ans_choice), 0);
    check("t6_rst_armed",  int'(armed),      0);
    tick(2);
    rst_n = 1'b1;
    watch_valid(30, seen);
    check("t6_held_no_ans", seen, 0);
    check("t6_held_no_arm", int'(armed), 0);
    joy_r = 4'b0;
    wait_armed("t6_rearm");
    joy_l = 4'b1000;
    tick(6);
    check("t6_valid2",  int'(ans_valid),  1);
    check("t6_player2", int'(ans_player), 0);
    check("t6_choice2", int'(ans_choice), 3);
    accept("t6_accept");
    joy_l = 4'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
